ac_frame_ctrl: RTL and testbench

Parametrised frame-level access controller for the up-sampling core. It replaces the fixed bundle of AXI-Lite config slave, AXI-Stream input slave, AXI-Stream output master and done-interrupt with one sequential block. The block holds a register file for frame geometry, start and interrupt control. It gates the input stream into the up-sampler by pixel/row counters, regenerates tlast/tuser on the up-scaled output stream, and raises a level interrupt at frame end. It sits between the SoC AXI fabric and the up-sampler datapath.

---
 rtl/ac_frame_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_ac_frame_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_frame_ctrl.sv
// Frame-level access controller for the up-sampling core: AXI-Lite register file,
// input-stream gating, output tlast/tuser regeneration and done interrupt.
// Optional build macro AC_TLAST_CHECK_EN enables input tlast checking (STATUS.ERR).
module ac_frame_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int DIM_WIDTH  = 12,
  parameter int SCALE_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axil_awaddr,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [7:0]            s_axil_araddr,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] us_in_data,
  output logic                  us_in_valid,
  input  logic                  us_in_ready,
  input  logic [DATA_WIDTH-1:0] us_out_data,
  input  logic                  us_out_valid,
  output logic                  us_out_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  interrupt_updone
);

  localparam int CW = DIM_WIDTH + SCALE_LOG2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h01;
  localparam logic [5:0] A_SRCW   = 6'h02;
  localparam logic [5:0] A_SRCH   = 6'h03;

  logic [0:0]           state_q, state_d;
  logic                 irq_en_q, irq_en_d;
  logic                 done_q, done_d;
  logic                 err_q;
  logic [DIM_WIDTH-1:0] src_w_q, src_w_d;
  logic [DIM_WIDTH-1:0] src_h_q, src_h_d;
  logic                 in_active_q, in_active_d;
  logic [DIM_WIDTH-1:0] in_col_q, in_col_d;
  logic [DIM_WIDTH-1:0] in_row_q, in_row_d;
  logic [CW-1:0]        out_col_q, out_col_d;
  logic [CW-1:0]        out_row_q, out_row_d;
  logic                 bvalid_q, bvalid_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 busy;
  logic                 wr_fire, rd_fire;
  logic [5:0]           wr_idx, rd_idx;
  logic                 wr_ctrl, wr_status, wr_srcw, wr_srch;
  logic                 start_ok;
  logic                 in_fire, in_col_last, in_row_last;
  logic                 out_fire, out_col_last, out_row_last, frame_end;
  logic [CW-1:0]        out_col_max, out_row_max;
  logic [31:0]          rd_word;
  logic                 unused_ok;

  assign busy    = (state_q == ST_RUN);
  assign wr_fire = s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
  assign rd_fire = s_axil_arvalid & ~rvalid_q;
  assign wr_idx  = s_axil_awaddr[7:2];
  assign rd_idx  = s_axil_araddr[7:2];

  assign wr_ctrl   = wr_fire && (wr_idx == A_CTRL);
  assign wr_status = wr_fire && (wr_idx == A_STATUS);
  assign wr_srcw   = wr_fire && (wr_idx == A_SRCW);
  assign wr_srch   = wr_fire && (wr_idx == A_SRCH);

  assign start_ok = wr_ctrl & s_axil_wdata[0] & ~busy &
                    (src_w_q != '0) & (src_h_q != '0);

  // Input geometry is in source pixels; output geometry is scaled by shifting.
  assign in_col_last = (in_col_q == src_w_q - DIM_WIDTH'(1));
  assign in_row_last = (in_row_q == src_h_q - DIM_WIDTH'(1));
  assign in_fire     = s_axis_tvalid & s_axis_tready;

  assign out_col_max  = (CW'(src_w_q) << SCALE_LOG2) - CW'(1);
  assign out_row_max  = (CW'(src_h_q) << SCALE_LOG2) - CW'(1);
  assign out_col_last = (out_col_q == out_col_max);
  assign out_row_last = (out_row_q == out_row_max);
  assign out_fire     = us_out_valid & m_axis_tready & busy;
  assign frame_end    = out_fire & out_col_last & out_row_last;

  assign s_axis_tready = us_in_ready & in_active_q & busy;
  assign us_in_valid   = s_axis_tvalid & in_active_q & busy;
  assign us_in_data    = s_axis_tdata;
  assign us_out_ready  = m_axis_tready & busy;
  assign m_axis_tvalid = us_out_valid & busy;
  assign m_axis_tdata  = us_out_data;
  assign m_axis_tlast  = busy & out_col_last;
  assign m_axis_tuser  = busy & (out_col_q == '0) & (out_row_q == '0);

  assign s_axil_awready   = wr_fire;
  assign s_axil_wready    = wr_fire;
  assign s_axil_arready   = rd_fire;
  assign s_axil_bvalid    = bvalid_q;
  assign s_axil_bresp     = 2'b00;
  assign s_axil_rvalid    = rvalid_q;
  assign s_axil_rdata     = rdata_q;
  assign s_axil_rresp     = 2'b00;
  assign interrupt_updone = irq_en_q & (done_q | err_q);

  assign unused_ok = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_wdata, s_axis_tlast};

  always_comb begin
    rd_word = 32'h0;
    case (rd_idx)
      A_CTRL:   rd_word = {30'h0, irq_en_q, 1'b0};
      A_STATUS: rd_word = {29'h0, err_q, done_q, busy};
      A_SRCW:   rd_word = 32'(src_w_q);
      A_SRCH:   rd_word = 32'(src_h_q);
      default:  rd_word = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    irq_en_d    = irq_en_q;
    src_w_d     = src_w_q;
    src_h_d     = src_h_q;
    in_active_d = in_active_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    out_col_d   = out_col_q;
    out_row_d   = out_row_q;
    bvalid_d    = wr_fire | (bvalid_q & ~s_axil_bready);
    rvalid_d    = rd_fire | (rvalid_q & ~s_axil_rready);
    rdata_d     = rd_fire ? rd_word : rdata_q;
    // A frame-end set takes priority over a simultaneous W1C.
    done_d      = frame_end | (done_q & ~(wr_status & s_axil_wdata[1]));

    if (wr_ctrl)            irq_en_d = s_axil_wdata[1];
    if (wr_srcw && !busy)   src_w_d  = s_axil_wdata[DIM_WIDTH-1:0];
    if (wr_srch && !busy)   src_h_d  = s_axil_wdata[DIM_WIDTH-1:0];

    if (start_ok) begin
      state_d     = ST_RUN;
      in_active_d = 1'b1;
      in_col_d    = '0;
      in_row_d    = '0;
      out_col_d   = '0;
      out_row_d   = '0;
    end

    if (busy && in_fire) begin
      if (in_col_last) begin
        in_col_d = '0;
        if (in_row_last) begin
          in_row_d    = '0;
          in_active_d = 1'b0;
        end else begin
          in_row_d = in_row_q + DIM_WIDTH'(1);
        end
      end else begin
        in_col_d = in_col_q + DIM_WIDTH'(1);
      end
    end

    if (out_fire) begin
      if (out_col_last) begin
        out_col_d = '0;
        if (out_row_last) begin
          out_row_d   = '0;
          state_d     = ST_IDLE;
          in_active_d = 1'b0;
        end else begin
          out_row_d = out_row_q + CW'(1);
        end
      end else begin
        out_col_d = out_col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      src_w_q     <= '0;
      src_h_q     <= '0;
      in_active_q <= 1'b0;
      in_col_q    <= '0;
      in_row_q    <= '0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      src_w_q     <= src_w_d;
      src_h_q     <= src_h_d;
      in_active_q <= in_active_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      out_col_q   <= out_col_d;
      out_row_q   <= out_row_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef AC_TLAST_CHECK_EN
  // Any accepted beat whose tlast disagrees with the column position flags ERR.
  logic err_set, err_d;
  assign err_set = busy & in_fire & (s_axis_tlast != in_col_last);
  assign err_d   = err_set | (err_q & ~(wr_status & s_axil_wdata[2]));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  assign err_q = 1'b0;
`endif

endmodule

// File: tb/tb_ac_frame_ctrl.sv
// Directed bench for ac_frame_ctrl: register access, frame sequencing, output
// framing, backpressure and DONE/ERR interrupt behaviour.
module tb_ac_frame_ctrl;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] s_tdata, us_in_data, us_out_data, m_tdata;
  logic          s_tvalid, s_tready, s_tlast;
  logic          us_in_valid, us_in_ready, us_out_valid, us_out_ready;
  logic          m_tvalid, m_tready, m_tlast, m_tuser, irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ac_frame_ctrl #(.DATA_WIDTH(DW), .DIM_WIDTH(12), .SCALE_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .us_in_data(us_in_data), .us_in_valid(us_in_valid), .us_in_ready(us_in_ready),
    .us_out_data(us_out_data), .us_out_valid(us_out_valid), .us_out_ready(us_out_ready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .interrupt_updone(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic axil_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axil_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0; d = rdata; rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic send_px(input int d, input logic last);
    @(negedge clk);
    s_tdata = DW'(d); s_tlast = last; s_tvalid = 1'b1; us_in_ready = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic out_beats(input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      us_out_valid = 1'b1; m_tready = 1'b1; us_out_data = DW'(j);
      @(posedge clk); #1;
      us_out_valid = 1'b0;
    end
  endtask

  logic [31:0] rv;

  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; wdata = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    s_tdata = '0; s_tvalid = 0; s_tlast = 0; us_in_ready = 0;
    us_out_data = '0; us_out_valid = 0; m_tready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    s_tvalid = 1; us_in_ready = 1; us_out_valid = 1; m_tready = 1;
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_us_in_valid", us_in_valid, 0);
    chk("rst_us_out_ready", us_out_ready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_irq", irq, 0);
    s_tvalid = 0; us_in_ready = 0; us_out_valid = 0; m_tready = 0;
    rst = 1'b0;

    axil_rd(8'h00, rv); chk("rst_ctrl", rv, 0);
    axil_rd(8'h04, rv); chk("rst_status", rv, 0);
    axil_rd(8'h08, rv); chk("rst_srcw", rv, 0);
    axil_rd(8'h0C, rv); chk("rst_srch", rv, 0);

    // START with zero width is ignored
    axil_wr(8'h0C, 32'd2);
    axil_wr(8'h00, 32'h1);
    axil_rd(8'h04, rv); chk("zw_busy", rv, 0);
    @(negedge clk); s_tvalid = 1; us_in_ready = 1; #1;
    chk("zw_tready", s_tready, 0);
    s_tvalid = 0;

    // Frame 1: 4x2 source -> 16x8 output, with mid-frame writes ignored
    axil_wr(8'h08, 32'd4);
    axil_wr(8'h0C, 32'd2);
    axil_wr(8'h00, 32'h3);
    axil_rd(8'h00, rv); chk("f1_ctrl", rv, 32'h2);
    axil_rd(8'h04, rv); chk("f1_busy", rv, 32'h1);
    axil_wr(8'h08, 32'd9);
    axil_wr(8'h00, 32'h3);
    axil_rd(8'h08, rv); chk("f1_srcw_kept", rv, 32'd4);
    axil_rd(8'h04, rv); chk("f1_status_kept", rv, 32'h1);
    axil_wr(8'h20, 32'hFFFF);
    axil_rd(8'h20, rv); chk("f1_unmapped", rv, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s_tdata = DW'(32'h100 + i); s_tlast = ((i % 4) == 3); s_tvalid = 1; us_in_ready = 1;
      #1;
      chk("f1_in_valid", us_in_valid, 1);
      chk("f1_in_ready", s_tready, 1);
      chk("f1_in_data", 32'(us_in_data), 32'h100 + i);
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("f1_in_closed", s_tready, 0);
    chk("f1_in_valid_closed", us_in_valid, 0);
    s_tvalid = 0;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      us_out_valid = 1; m_tready = 1; us_out_data = DW'(j + 7);
      #1;
      chk("f1_m_tvalid", m_tvalid, 1);
      chk("f1_m_tlast", m_tlast, ((j % 16) == 15));
      chk("f1_m_tuser", m_tuser, (j == 0));
      if (j == 127) chk("f1_irq_pre", irq, 0);
      if (j == 37) chk("f1_m_tdata", 32'(m_tdata), 32'd44);
      @(posedge clk); #1;
    end
    us_out_valid = 0;
    chk("f1_irq_done", irq, 1);
    chk("f1_m_tvalid_idle", m_tvalid, 0);
    axil_rd(8'h04, rv); chk("f1_status_done", rv, 32'h2);

    // Frame 2: 1x1; W1C of DONE lands on the frame-end edge, set wins
    axil_wr(8'h08, 32'd1);
    axil_wr(8'h0C, 32'd1);
    axil_wr(8'h00, 32'h3);
    send_px(32'h55, 1'b1);
    out_beats(15);
    @(negedge clk);
    us_out_valid = 1; m_tready = 1;
    awaddr = 8'h04; wdata = 32'h2; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    us_out_valid = 0; awvalid = 0; wvalid = 0; bready = 1;
    @(posedge clk); #1;
    bready = 0;
    axil_rd(8'h04, rv); chk("sw_done_kept", rv, 32'h2);
    chk("sw_irq_kept", irq, 1);
    axil_wr(8'h04, 32'h2);
    axil_rd(8'h04, rv); chk("sw_done_clr", rv, 0);
    chk("sw_irq_clr", irq, 0);

    // Frame 3: 3x3 with random backpressure -> 144 output beats, 12 tlast
    axil_wr(8'h08, 32'd3);
    axil_wr(8'h0C, 32'd3);
    axil_wr(8'h00, 32'h3);
    fork
      begin
        int n = 0;
        int cyc = 0;
        while (n < 9 && cyc < 3000) begin
          @(negedge clk);
          s_tvalid = 1'($urandom_range(0, 1)); us_in_ready = 1'($urandom_range(0, 1));
          s_tdata = DW'(32'h200 + n); s_tlast = ((n % 3) == 2);
          #1;
          if (us_in_valid && us_in_ready) begin
            chk("rnd_in_data", 32'(us_in_data), 32'h200 + n);
            n++;
          end
          @(posedge clk); cyc++;
        end
        s_tvalid = 0;
        chk("rnd_in_count", n, 9);
      end
      begin
        int m = 0;
        int nl = 0;
        int nu = 0;
        int derr = 0;
        int cyc = 0;
        while (m < 144 && cyc < 5000) begin
          @(negedge clk);
          us_out_valid = 1'($urandom_range(0, 1)); m_tready = 1'($urandom_range(0, 1));
          us_out_data = DW'(32'h3000 + m);
          #1;
          if (m_tvalid && m_tready) begin
            if (m_tlast) nl++;
            if (m_tuser) nu++;
            if (32'(m_tdata) != 32'h3000 + m) derr++;
            m++;
          end
          @(posedge clk); cyc++;
        end
        @(negedge clk);
        us_out_valid = 1; m_tready = 1;
        #1;
        chk("rnd_no_extra", m_tvalid, 0);
        us_out_valid = 0;
        chk("rnd_out_count", m, 144);
        chk("rnd_tlast_count", nl, 12);
        chk("rnd_tuser_count", nu, 1);
        chk("rnd_data_err", derr, 0);
      end
    join
    chk("rnd_irq", irq, 1);
    axil_wr(8'h04, 32'h2);

    // Frame 4: 4x1 with tlast on column 1 instead of column 3
    axil_wr(8'h08, 32'd4);
    axil_wr(8'h0C, 32'd1);
    axil_wr(8'h00, 32'h3);
    for (int i = 0; i < 4; i++) send_px(32'h400 + i, (i == 1));
`ifdef AC_TLAST_CHECK_EN
    chk("tl_irq_err", irq, 1);
    axil_rd(8'h04, rv); chk("tl_status_run", rv, 32'h5);
`else
    chk("tl_irq_err", irq, 0);
    axil_rd(8'h04, rv); chk("tl_status_run", rv, 32'h1);
`endif
    out_beats(64);
`ifdef AC_TLAST_CHECK_EN
    axil_rd(8'h04, rv); chk("tl_status_end", rv, 32'h6);
`else
    axil_rd(8'h04, rv); chk("tl_status_end", rv, 32'h2);
`endif
    chk("tl_irq_end", irq, 1);
    axil_wr(8'h04, 32'h6);
    axil_rd(8'h04, rv); chk("tl_status_clr", rv, 0);
    chk("tl_irq_clr", irq, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
